// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command controller: command opcodes,
// operand register addresses and the controller state encoding.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_OPA,
        ST_OPB,
        ST_ALU_FUN_S,
        ST_ALU_WAIT,
        ST_TX_LO,
        ST_TX_HI,
        ST_TX_RD
    } cmd_state_e;

endpackage

// File: rtl/uart_cmd_ctrl_tx_push.sv
// Byte-push sequencer toward the TX FIFO: accepts a byte when the FIFO is not
// full and issues a registered one-cycle push strobe; the data register holds while stalled.
module uart_cmd_tx_push #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_req,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  fifo_full,
    output logic                  push_ack,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic                  fifo_wr_inc
);

    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  wr_inc_q, wr_inc_d;

    assign push_ack = push_req & ~fifo_full;

    always_comb begin
        wr_data_d = wr_data_q;
        wr_inc_d  = 1'b0;
        if (push_ack) begin
            wr_data_d = push_data;
            wr_inc_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_data_q <= '0;
            wr_inc_q  <= 1'b0;
        end else begin
            wr_data_q <= wr_data_d;
            wr_inc_q  <= wr_inc_d;
        end
    end

    assign fifo_wr_data = wr_data_q;
    assign fifo_wr_inc  = wr_inc_q;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Multi-frame UART command decoder driving the register file, the ALU and the TX FIFO.
// Optional inter-frame timeout is compiled in with CMD_CTRL_TIMEOUT_EN.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int ALU_FUN_WIDTH  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     REF_CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    output logic [ADDR_WIDTH-1:0]    RF_ADDR,
    output logic                     RF_WR_EN,
    output logic [DATA_WIDTH-1:0]    RF_WR_DATA,
    output logic                     RF_RD_EN,
    input  logic [DATA_WIDTH-1:0]    RF_RD_DATA,
    input  logic                     RF_RD_DATA_VLD,
    output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
    output logic                     ALU_EN,
    input  logic [2*DATA_WIDTH-1:0]  ALU_OUT,
    input  logic                     ALU_OUT_VLD,
    output logic                     CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]    FIFO_WR_DATA,
    output logic                     FIFO_WR_INC,
    input  logic                     FIFO_FULL
);

    cmd_state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0]     wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0]     rf_addr_q, rf_addr_d;
    logic                      rf_wr_en_q, rf_wr_en_d;
    logic [DATA_WIDTH-1:0]     rf_wr_data_q, rf_wr_data_d;
    logic                      rf_rd_en_q, rf_rd_en_d;
    logic [ALU_FUN_WIDTH-1:0]  alu_fun_q, alu_fun_d;
    logic                      alu_en_q, alu_en_d;
    logic [DATA_WIDTH-1:0]     rd_data_q, rd_data_d;
    logic [2*DATA_WIDTH-1:0]   alu_res_q, alu_res_d;

    logic                      push_req;
    logic [DATA_WIDTH-1:0]     push_data;
    logic                      push_ack;

`ifdef CMD_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_armed;
`endif

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        rf_addr_d    = rf_addr_q;
        rf_wr_en_d   = 1'b0;
        rf_wr_data_d = rf_wr_data_q;
        rf_rd_en_d   = 1'b0;
        alu_fun_d    = alu_fun_q;
        alu_en_d     = 1'b0;
        rd_data_d    = rd_data_q;
        alu_res_d    = alu_res_q;
        push_req     = 1'b0;
        push_data    = rd_data_q;

        case (state_q)
            ST_IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        CMD_RF_WR:   state_d = ST_WR_ADDR;
                        CMD_RF_RD:   state_d = ST_RD_ADDR;
                        CMD_ALU_OP:  state_d = ST_OPA;
                        CMD_ALU_NOP: state_d = ST_ALU_FUN_S;
                        default:     state_d = ST_IDLE;
                    endcase
                end
            end
            ST_WR_ADDR: begin
                if (RX_D_VLD) begin
                    wr_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d   = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (RX_D_VLD) begin
                    rf_wr_en_d   = 1'b1;
                    rf_addr_d    = wr_addr_q;
                    rf_wr_data_d = RX_P_DATA;
                    state_d      = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (RX_D_VLD) begin
                    rf_rd_en_d = 1'b1;
                    rf_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d    = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (RF_RD_DATA_VLD) begin
                    rd_data_d = RF_RD_DATA;
                    state_d   = ST_TX_RD;
                end
            end
            ST_OPA: begin
                if (RX_D_VLD) begin
                    rf_wr_en_d   = 1'b1;
                    rf_addr_d    = ADDR_WIDTH'(OPA_ADDR);
                    rf_wr_data_d = RX_P_DATA;
                    state_d      = ST_OPB;
                end
            end
            ST_OPB: begin
                if (RX_D_VLD) begin
                    rf_wr_en_d   = 1'b1;
                    rf_addr_d    = ADDR_WIDTH'(OPB_ADDR);
                    rf_wr_data_d = RX_P_DATA;
                    state_d      = ST_ALU_FUN_S;
                end
            end
            ST_ALU_FUN_S: begin
                if (RX_D_VLD) begin
                    alu_fun_d = RX_P_DATA[ALU_FUN_WIDTH-1:0];
                    alu_en_d  = 1'b1;
                    state_d   = ST_ALU_WAIT;
                end
            end
            ST_ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    alu_res_d = ALU_OUT;
                    state_d   = ST_TX_LO;
                end
            end
            ST_TX_LO: begin
                push_req  = 1'b1;
                push_data = alu_res_q[DATA_WIDTH-1:0];
                if (push_ack) state_d = ST_TX_HI;
            end
            ST_TX_HI: begin
                push_req  = 1'b1;
                push_data = alu_res_q[2*DATA_WIDTH-1:DATA_WIDTH];
                if (push_ack) state_d = ST_IDLE;
            end
            ST_TX_RD: begin
                push_req  = 1'b1;
                push_data = rd_data_q;
                if (push_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef CMD_CTRL_TIMEOUT_EN
        // Frame-waiting states only; a silent line drops the command without any strobe.
        tmo_armed = (state_q inside {ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR,
                                     ST_OPA, ST_OPB, ST_ALU_FUN_S});
        tmo_cnt_d = '0;
        if (tmo_armed && !RX_D_VLD) begin
            if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = ST_IDLE;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge REF_CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            wr_addr_q    <= '0;
            rf_addr_q    <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_wr_data_q <= '0;
            rf_rd_en_q   <= 1'b0;
            alu_fun_q    <= '0;
            alu_en_q     <= 1'b0;
            rd_data_q    <= '0;
            alu_res_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            rf_addr_q    <= rf_addr_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_wr_data_q <= rf_wr_data_d;
            rf_rd_en_q   <= rf_rd_en_d;
            alu_fun_q    <= alu_fun_d;
            alu_en_q     <= alu_en_d;
            rd_data_q    <= rd_data_d;
            alu_res_q    <= alu_res_d;
        end
    end

`ifdef CMD_CTRL_TIMEOUT_EN
    always_ff @(posedge REF_CLK or negedge RST) begin
        if (!RST) tmo_cnt_q <= '0;
        else      tmo_cnt_q <= tmo_cnt_d;
    end
`endif

    uart_cmd_tx_push #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tx_push (
        .clk          (REF_CLK),
        .rst_n        (RST),
        .push_req     (push_req),
        .push_data    (push_data),
        .fifo_full    (FIFO_FULL),
        .push_ack     (push_ack),
        .fifo_wr_data (FIFO_WR_DATA),
        .fifo_wr_inc  (FIFO_WR_INC)
    );

    // The ALU clock runs exactly while a function frame or its result is outstanding.
    assign CLK_GATE_EN = (state_q == ST_ALU_FUN_S) || (state_q == ST_ALU_WAIT);

    assign RF_ADDR    = rf_addr_q;
    assign RF_WR_EN   = rf_wr_en_q;
    assign RF_WR_DATA = rf_wr_data_q;
    assign RF_RD_EN   = rf_rd_en_q;
    assign ALU_FUN    = alu_fun_q;
    assign ALU_EN     = alu_en_q;

endmodule
